// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the PC and steps each instruction through fetch,
// decode, execute and update, resolving jumps and relative branches from latched flags.
module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          FLAG_Z   = 6,
  parameter int          FLAG_N   = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [15:0] ir,
  output logic        exec_en,
  input  logic        exec_done,
  input  logic        flags_we,
  input  logic [7:0]  flags_in,
  input  logic [15:0] jtarget,
  output logic [15:0] pc,
  output logic        taken,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT_DONE,
    ST_UPDATE
  } state_t;

  state_t      state_reg, state_next;
  logic [15:0] pc_reg, pc_next;
  logic [15:0] ir_reg;
  logic [7:0]  flags_reg;
  logic        is_jump_reg, is_branch_reg;
  logic        cond_true, redirect;
  logic [15:0] disp_ext;

  // Condition uses the registered flags, so a same-cycle flags_we only affects later decisions.
  always_comb begin
    cond_true = 1'b0;
    case (ir_reg[11:8])
      4'b0000: cond_true = flags_reg[FLAG_Z];
      4'b0001: cond_true = !flags_reg[FLAG_Z];
      4'b0110: cond_true = is_jump_reg ? (flags_reg[FLAG_Z] | flags_reg[FLAG_N])
                                       : flags_reg[FLAG_N];
      4'b0111: cond_true = !flags_reg[FLAG_N];
      4'b1110: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

  assign redirect = (is_jump_reg | is_branch_reg) & cond_true;
  assign disp_ext = {{8{ir_reg[7]}}, ir_reg[7:0]};

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      ST_IDLE:      if (run) state_next = ST_FETCH;
      ST_FETCH:     if (imem_ack) state_next = ST_DECODE;
      ST_DECODE:    state_next = ST_EXEC;
      ST_EXEC:      state_next = (is_jump_reg | is_branch_reg) ? ST_UPDATE : ST_WAIT_DONE;
      ST_WAIT_DONE: if (exec_done) state_next = ST_UPDATE;
      ST_UPDATE: begin
        if (redirect && is_jump_reg) pc_next = jtarget;
        else if (redirect)           pc_next = pc_reg + disp_ext;
        else                         pc_next = pc_reg + 16'd1;
        state_next = run ? ST_FETCH : ST_IDLE;
      end
      default:      state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= RESET_PC;
      ir_reg        <= 16'h0000;
      flags_reg     <= 8'h00;
      is_jump_reg   <= 1'b0;
      is_branch_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      if (flags_we) flags_reg <= flags_in;
      if (state_reg == ST_FETCH && imem_ack) ir_reg <= imem_data;
      if (state_reg == ST_DECODE) begin
        is_jump_reg   <= (ir_reg[15:12] == 4'b0100) && (ir_reg[7:4] == 4'b1100);
        is_branch_reg <= (ir_reg[15:12] == 4'b1100);
      end
    end
  end

  // Every output is a function of registered state only.
  assign imem_req  = (state_reg == ST_FETCH);
  assign imem_addr = pc_reg;
  assign ir        = ir_reg;
  assign pc        = pc_reg;
  assign exec_en   = (state_reg == ST_EXEC) && !(is_jump_reg | is_branch_reg);
  assign taken     = (state_reg == ST_UPDATE) && redirect;
  assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: memory and datapath models drive the DUT; a monitor
// checks every fetch handshake against a queue of expected transactions.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] ir;
  logic        exec_en;
  logic        exec_done = 1'b0;
  logic        flags_we = 1'b0;
  logic [7:0]  flags_in = 8'h00;
  logic [15:0] jtarget;
  logic [15:0] pc;
  logic        taken;
  logic        busy;

  logic [15:0] mem [0:65535];
  logic [15:0] regs [0:15];
  int          ack_dly = 0;
  int          done_dly = 1;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [15:0] addr;
    bit          tk;
    int          pulses;
    int          cyc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign jtarget = regs[ir[3:0]];

  pc_sequencer #(.RESET_PC(16'h0000), .FLAG_Z(6), .FLAG_N(7)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir), .exec_en(exec_en), .exec_done(exec_done),
    .flags_we(flags_we), .flags_in(flags_in), .jtarget(jtarget),
    .pc(pc), .taken(taken), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Expected fetch at addr; tk/pulses describe the preceding instruction; cyc=0 skips the interval check.
  task automatic expect_fetch(input logic [15:0] a, input bit tk, input int p, input int c);
    exp_q.push_back('{a, tk, p, c});
  endtask

  task automatic wait_exec(input logic [15:0] want, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (exec_en && ir == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Instruction memory with programmable ack latency; address must hold while waiting.
  initial begin : mem_drv
    bit          req_prev;
    bit          acked;
    logic [15:0] hold_addr;
    int          wcnt;
    req_prev = 1'b0;
    acked = 1'b0;
    hold_addr = 16'h0000;
    wcnt = 0;
    forever begin
      @(posedge clk); #1;
      if (imem_req && rst_n) begin
        if (!req_prev) begin
          hold_addr = imem_addr;
          wcnt = 0;
        end else begin
          check("fetch_addr_hold", {16'h0, imem_addr}, {16'h0, hold_addr});
        end
        imem_ack = (wcnt >= ack_dly);
        acked = imem_ack;
        imem_data = mem[imem_addr];
        wcnt++;
        req_prev = 1'b1;
      end else begin
        if (req_prev && !acked && rst_n) check("fetch_req_held", {31'h0, imem_req}, 32'h1);
        imem_ack = 1'b0;
        req_prev = 1'b0;
        acked = 1'b0;
      end
    end
  end

  // Datapath: exec_done done_dly cycles after exec_en; opcode 1 writes flags from ir[7:0].
  initial begin : dp_drv
    int          pend;
    logic [15:0] cur;
    pend = 0;
    cur = 16'h0000;
    forever begin
      @(posedge clk); #1;
      exec_done = 1'b0;
      flags_we = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          exec_done = 1'b1;
          if (cur[15:12] == 4'h1) begin
            flags_we = 1'b1;
            flags_in = cur[7:0];
          end
        end
      end
      if (exec_en) begin
        pend = done_dly;
        cur = ir;
      end
    end
  end

  initial begin : monitor
    int   pulses;
    int   cyc;
    bit   tk;
    exp_t e;
    pulses = 0;
    cyc = 0;
    tk = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pulses = 0;
        cyc = 0;
        tk = 1'b0;
      end else begin
        cyc++;
        if (exec_en) pulses++;
        if (taken) tk = 1'b1;
        if (imem_req && imem_ack) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_fetch: got addr %h, expected no fetch", imem_addr);
          end else begin
            e = exp_q.pop_front();
            $display("fetch addr=%h data=%h prev_taken=%0d prev_exec=%0d interval=%0d",
                     imem_addr, imem_data, tk, pulses, cyc);
            check("fetch_addr", {16'h0, imem_addr}, {16'h0, e.addr});
            check("prev_taken", {31'h0, tk}, {31'h0, e.tk});
            check("prev_exec_pulses", pulses, e.pulses);
            if (e.cyc != 0) check("fetch_interval", cyc, e.cyc);
          end
          pulses = 0;
          tk = 1'b0;
          cyc = 0;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    bit ok;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 16; i++) regs[i] = 16'h0000;
    regs[0] = 16'h0010;
    regs[1] = 16'h1234;
    regs[2] = 16'hFFFF;
    regs[3] = 16'h0020;

    mem[16'h0003] = 16'h1040;  // flags <= 0x40 (Z=1, N=0)
    mem[16'h0004] = 16'h4EC0;  // JUMP UC -> 0x0010
    mem[16'h0010] = 16'hC0FC;  // BRANCH EQ -4, taken
    mem[16'h000C] = 16'h4EC1;  // JUMP UC -> 0x1234
    mem[16'h1234] = 16'h1000;  // flags <= 0
    mem[16'h1235] = 16'hC0FC;  // BRANCH EQ, not taken
    mem[16'h1236] = 16'h1040;  // flags <= 0x40
    mem[16'h1237] = 16'h46C3;  // JUMP GT via Z -> 0x0020
    mem[16'h0020] = 16'hC610;  // BRANCH GT, N=0 not taken
    mem[16'h0021] = 16'hC105;  // BRANCH NE, not taken
    mem[16'h0022] = 16'hC702;  // BRANCH LE +2, taken
    mem[16'h0024] = 16'hCE01;  // BRANCH UC +1, taken
    mem[16'h0025] = 16'h4EC2;  // JUMP UC -> 0xFFFF
    mem[16'hFFFF] = 16'h2000;  // ordinary, wraps to 0x0000

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_pc", {16'h0, pc}, 32'h0);
    check("reset_ir", {16'h0, ir}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_imem_req", {31'h0, imem_req}, 32'h0);
    check("reset_exec_en", {31'h0, exec_en}, 32'h0);
    check("reset_taken", {31'h0, taken}, 32'h0);

    expect_fetch(16'h0000, 0, 0, 0);
    expect_fetch(16'h0001, 0, 1, 5);
    expect_fetch(16'h0002, 0, 1, 5);
    expect_fetch(16'h0003, 0, 1, 5);
    expect_fetch(16'h0004, 0, 1, 5);
    expect_fetch(16'h0010, 1, 0, 4);
    expect_fetch(16'h000C, 1, 0, 4);
    expect_fetch(16'h1234, 1, 0, 4);
    expect_fetch(16'h1235, 0, 1, 5);
    expect_fetch(16'h1236, 0, 0, 4);
    expect_fetch(16'h1237, 0, 1, 5);
    expect_fetch(16'h0020, 1, 0, 4);
    expect_fetch(16'h0021, 0, 0, 4);
    expect_fetch(16'h0022, 0, 0, 4);
    expect_fetch(16'h0024, 1, 0, 4);
    expect_fetch(16'h0025, 1, 0, 4);
    expect_fetch(16'hFFFF, 1, 0, 4);

    @(posedge clk); #1;
    rst_n = 1'b1;
    run = 1'b1;
    wait_exec(16'h2000, ok);
    check("reach_ffff_exec", {31'h0, ok}, 32'h1);
    run = 1'b0;
    wait_idle(ok);
    check("p1_stop_idle", {31'h0, ok}, 32'h1);
    @(negedge clk);
    check("p1_pc_wrap", {16'h0, pc}, 32'h0000);
    check("p1_busy", {31'h0, busy}, 32'h0);
    check("p1_queue_drained", exp_q.size(), 0);

    // Slow memory, branch across the top of the address space, run dropped mid-execute.
    mem[16'h0000] = 16'h4EC2;
    mem[16'hFFFF] = 16'hC002;
    ack_dly = 3;
    done_dly = 3;
    expect_fetch(16'h0000, 0, 1, 0);
    expect_fetch(16'hFFFF, 1, 0, 7);
    expect_fetch(16'h0001, 1, 0, 7);
    run = 1'b1;
    wait_exec(16'h0000, ok);
    check("p2_reach_exec", {31'h0, ok}, 32'h1);
    run = 1'b0;
    wait_idle(ok);
    check("p2_stop_idle", {31'h0, ok}, 32'h1);
    @(negedge clk);
    check("p2_pc_after_stop", {16'h0, pc}, 32'h0002);
    check("p2_busy", {31'h0, busy}, 32'h0);
    check("p2_queue_drained", exp_q.size(), 0);

    // Reset in the middle of execute aborts immediately; the late exec_done is ignored.
    ack_dly = 0;
    done_dly = 5;
    expect_fetch(16'h0002, 0, 1, 0);
    run = 1'b1;
    wait_exec(16'h0000, ok);
    check("p3_reach_exec", {31'h0, ok}, 32'h1);
    @(posedge clk); #1;
    run = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("p3_reset_pc", {16'h0, pc}, 32'h0);
    check("p3_reset_busy", {31'h0, busy}, 32'h0);
    check("p3_reset_exec_en", {31'h0, exec_en}, 32'h0);
    check("p3_reset_ir", {16'h0, ir}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("p3_after_done_pc", {16'h0, pc}, 32'h0);
    check("p3_after_done_busy", {31'h0, busy}, 32'h0);
    check("p3_after_done_taken", {31'h0, taken}, 32'h0);
    check("p3_queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing controller for the 16-bit CPU.
- Owns the program counter and steps each instruction through FETCH/DECODE/EXECUTE/UPDATE with a handshake to instruction memory and a done handshake from the datapath.
- Latches ALU flags and resolves conditional jumps (absolute) and branches (PC-relative) to produce the next PC.
- Sits between instruction memory, the register file/ALU datapath and the top-level run control.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset.
FLAG_Z, 6, bit index of the Z flag in the flag byte.
FLAG_N, 7, bit index of the N (greater) flag in the flag byte.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  level; 1 = sequence instructions, 0 = stop at next instruction boundary
imem_req  output  1  instruction fetch request
imem_addr  output  16  fetch address (equals pc)
imem_ack  input  1  fetch data valid this cycle
imem_data  input  16  fetched instruction
ir  output  16  instruction register
exec_en  output  1  one-cycle pulse: datapath executes ir
exec_done  input  1  datapath finished the instruction
flags_we  input  1  flags_in valid; latch it
flags_in  input  8  ALU flag byte
jtarget  input  16  register-file value for absolute jump target
pc  output  16  program counter
taken  output  1  one-cycle pulse in UPDATE when a jump/branch redirects the PC
busy  output  1  1 in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, flags=0, imem_req=0, exec_en=0, taken=0, busy=0. Reset mid-fetch or mid-execute aborts immediately; no PC update.
- IDLE: if run=1, go to FETCH on the next edge; otherwise stay.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held until imem_ack.
  - On a cycle with imem_ack=1: ir<=imem_data, go to DECODE.
  - No timeout; the state waits indefinitely for imem_ack.
- DECODE: one cycle. Classify ir:
  - JUMP: ir[15:12]=4'b0100 and ir[7:4]=4'b1100, cond=ir[11:8].
  - BRANCH: ir[15:12]=4'b1100, cond=ir[11:8], disp=ir[7:0].
  - Any other encoding is an ordinary instruction.
- EXECUTE:
  - exec_en=1 for the first cycle only; then wait for exec_done=1 and go to UPDATE.
  - JUMP/BRANCH do not pulse exec_en and go directly to UPDATE after one cycle.
  - exec_done outside EXECUTE is ignored.
- Flags:
  - flags<=flags_in on any cycle with flags_we=1 (any state except reset).
  - If flags_we and the UPDATE decision fall in the same cycle, the decision uses the old flags.
- Condition evaluation (Z=flags[FLAG_Z], N=flags[FLAG_N]):
  - EQ 0000: Z=1. NE 0001: Z=0.
  - GT 0110: N=1 for BRANCH; Z=1 or N=1 for JUMP.
  - LE 0111: N=0. UC 1110: always true.
  - Every other cond: false (falls through to pc+1).
- UPDATE: one cycle.
  - JUMP true: pc<=jtarget.
  - BRANCH true: pc<=pc+sign_extend(disp), where pc is the branch's own address.
  - BRANCH UC: also relative (pc+sext(disp)).
  - Otherwise: pc<=pc+1.
  - taken=1 when redirected (including a redirect to pc+1 by disp=1).
  - Next state is FETCH if run=1, else IDLE.
- Width rules: all PC arithmetic is modulo 2^16. 16'hFFFF+1 wraps to 16'h0000. Negative displacement wraps below 0.
- run deassert during FETCH/DECODE/EXECUTE: the current instruction completes and stops in IDLE after UPDATE.
- Outputs are registered or decoded from state only; no combinational path from imem_ack to imem_req.
- Latency, 0-wait memory: an ordinary instruction with exec_done in the cycle after exec_en takes 5 cycles (FETCH, DECODE, EXECUTE x2, UPDATE). A JUMP/BRANCH takes 4 cycles.

Test Plan:
1. Reset then run=1, imem_ack held 1, NOP stream (16'h0000), exec_done 1 cycle after exec_en -> pc = 0, 1, 2, …; exec_en pulses once per instruction; taken never 1.
2. flags_in=8'h40 latched; BRANCH EQ disp=8'hFC at pc=16'h0010 -> pc=16'h000C, taken=1. Repeat with flags=0 -> pc=16'h0011, taken=0.
3. JUMP UC with jtarget=16'h1234 -> pc=16'h1234. JUMP GT with flags=8'h40 -> taken (Z path). BRANCH GT with flags=8'h40 -> not taken.
4. pc=16'hFFFF, ordinary instruction -> pc=16'h0000. BRANCH disp=8'h02 at 16'hFFFF -> pc=16'h0001.
5. imem_ack delayed 3 cycles -> imem_req and imem_addr stable for all wait cycles. run dropped in EXECUTE -> completes UPDATE, then IDLE with busy=0.
6. rst_n asserted mid-EXECUTE -> immediate IDLE, pc=RESET_PC, exec_en=0. Later exec_done pulses are ignored.
